tx_iod_training_pattern_gen: RTL and testbench

// - Transmit-side partner of the RX IOD clock-training / bit-align path.
// - Drives the 8-bit parallel TX_DATA of a TX IOD lane (DDRX, 1600 Mbps) from the FAB_CLK domain.
// - Sends a training pattern while the far-end receiver eye-monitors and bit-aligns.
// - Then sends a sync word, then passes user data with a valid/ready handshake.
//

---
 rtl/tx_iod_train_pkg.sv | 40 ++++
 rtl/prbs7_par8.sv | 37 +++
 rtl/tx_iod_training_pattern_gen.sv | 158 +++++++++++++++
 tb/tb_tx_iod_training_pattern_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_iod_train_pkg.sv
//============================================================================
// tx_iod_train_pkg : shared encodings and PRBS7 helper for the TX IOD trainer
// Revision 1.0
//============================================================================
`default_nettype none

package tx_iod_train_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_SYNC  = 2'd2,
    ST_DATA  = 2'd3
  } tx_state_e;

  localparam logic [1:0] PSEL_CLK     = 2'd0;
  localparam logic [1:0] PSEL_PRBS7   = 2'd1;
  localparam logic [1:0] PSEL_USER    = 2'd2;
  localparam logic [1:0] PSEL_CLK_ALT = 2'd3;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  // Eight serial steps of x^7+x^6+1; returns {state_after_8_bits, word}, bit 0 first.
  function automatic logic [14:0] prbs7_adv8(input logic [6:0] seed);
    logic [6:0] s;
    logic [7:0] w;
    logic       b;
    s = seed;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      b    = s[6] ^ s[5];
      w[i] = b;
      s    = {s[5:0], b};
    end
    return {s, w};
  endfunction

endpackage

`default_nettype wire

// File: rtl/prbs7_par8.sv
//============================================================================
// prbs7_par8 : PRBS7 generator producing one 8-bit word per enabled cycle
// Revision 1.0
//============================================================================
`default_nettype none

module prbs7_par8
  import tx_iod_train_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       reseed,
  output logic [7:0] word
);

  logic [6:0]  lfsr;
  logic [14:0] adv;

  always_comb adv = prbs7_adv8(lfsr);

  assign word = adv[7:0];

  // Reseed takes priority so a restart always begins exactly at the seed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= PRBS7_SEED;
    end else if (reseed) begin
      lfsr <= PRBS7_SEED;
    end else if (en) begin
      lfsr <= adv[14:8];
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_iod_training_pattern_gen.sv
//============================================================================
// tx_iod_training_pattern_gen : TX lane training pattern / sync word / data mux
// Revision 1.0
//============================================================================
`default_nettype none

module tx_iod_training_pattern_gen
  import tx_iod_train_pkg::*;
#(
  parameter logic [7:0]  IDLE_WORD      = 8'h00,
  parameter logic [7:0]  CLK_PATTERN    = 8'h55,
  parameter logic [7:0]  SYNC_WORD      = 8'hB8,
  parameter int unsigned SYNC_LEN       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
)(
  input  logic       fab_clk,
  input  logic       arst_n,
  input  logic       tx_sync_rst,
  input  logic       train_req,
  input  logic       train_done,
  input  logic [1:0] pattern_sel,
  input  logic [7:0] user_pattern,
  input  logic [7:0] tx_data_in,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic [7:0] tx_data_0,
  output logic [1:0] tx_state,
  output logic       train_timeout
);

  localparam int unsigned TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]  SYNC_LAST   = 8'(SYNC_LEN - 1);

  tx_state_e     state;
  tx_state_e     state_nxt;
  logic [7:0]    word_nxt;
  logic          train_entry;
  logic          prbs_en;
  logic [7:0]    prbs_word;
  logic          ready;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_inc;
  logic [7:0]    sync_cnt;
  logic [7:0]    data_q;
  logic          timeout_q;

  // Combinational so a retrain request blocks acceptance in the same cycle.
  assign ready         = (state == ST_DATA) && !train_req;
  assign tx_data_ready = ready;
  assign tx_data_0     = data_q;
  assign tx_state      = state;
  assign train_timeout = timeout_q;
  assign tmo_inc       = tmo_cnt + 1'b1;

  prbs7_par8 u_prbs (
    .clk    (fab_clk),
    .rst_n  (arst_n),
    .en     (prbs_en),
    .reseed (train_entry | tx_sync_rst),
    .word   (prbs_word)
  );

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= ST_IDLE;
    end else if (tx_sync_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    word_nxt    = IDLE_WORD;
    train_entry = 1'b0;
    prbs_en     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (train_req) begin
          state_nxt   = ST_TRAIN;
          train_entry = 1'b1;
        end
      end
      ST_TRAIN: begin
        unique case (pattern_sel)
          PSEL_PRBS7: begin
            word_nxt = prbs_word;
            prbs_en  = 1'b1;
          end
          PSEL_USER:    word_nxt = user_pattern;
          PSEL_CLK,
          PSEL_CLK_ALT: word_nxt = CLK_PATTERN;
          default:      word_nxt = CLK_PATTERN;
        endcase
        if (train_done) begin
          state_nxt = ST_SYNC;
        end
      end
      ST_SYNC: begin
        word_nxt = SYNC_WORD;
        if (train_req) begin
          state_nxt   = ST_TRAIN;
          train_entry = 1'b1;
        end else if (sync_cnt == SYNC_LAST) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_data_valid && ready) begin
          word_nxt = tx_data_in;
        end
        if (train_req) begin
          state_nxt   = ST_TRAIN;
          train_entry = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      data_q    <= IDLE_WORD;
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
      sync_cnt  <= '0;
    end else if (tx_sync_rst) begin
      data_q    <= IDLE_WORD;
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
      sync_cnt  <= '0;
    end else begin
      data_q <= word_nxt;

      // Saturating count: the flag stays set and the pattern keeps running.
      if (train_entry) begin
        tmo_cnt   <= '0;
        timeout_q <= 1'b0;
      end else if ((state == ST_TRAIN) && (tmo_cnt != TMO_LIMIT)) begin
        tmo_cnt <= tmo_inc;
        if (tmo_inc == TMO_LIMIT) begin
          timeout_q <= 1'b1;
        end
      end

      if ((state == ST_SYNC) && (state_nxt == ST_SYNC)) begin
        sync_cnt <= sync_cnt + 8'd1;
      end else begin
        sync_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tx_iod_training_pattern_gen.sv
//============================================================================
// tb_tx_iod_training_pattern_gen : scoreboard bench for the TX training generator
// Revision 1.0
//============================================================================
`default_nettype none

module tb_tx_iod_training_pattern_gen;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRAIN = 2'd1;
  localparam logic [1:0] S_SYNC  = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  logic       fab_clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       tx_sync_rst = 1'b0;
  logic       train_req = 1'b0;
  logic       train_done = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] user_pattern = 8'h3C;
  logic [7:0] tx_data_in = 8'h00;
  logic       tx_data_valid = 1'b0;
  logic       tx_data_ready;
  logic [7:0] tx_data_0;
  logic [1:0] tx_state;
  logic       train_timeout;

  always #5 fab_clk = ~fab_clk;

  tx_iod_training_pattern_gen #(
    .IDLE_WORD      (8'h00),
    .CLK_PATTERN    (8'h55),
    .SYNC_WORD      (8'hB8),
    .SYNC_LEN       (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .fab_clk       (fab_clk),
    .arst_n        (arst_n),
    .tx_sync_rst   (tx_sync_rst),
    .train_req     (train_req),
    .train_done    (train_done),
    .pattern_sel   (pattern_sel),
    .user_pattern  (user_pattern),
    .tx_data_in    (tx_data_in),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .tx_data_0     (tx_data_0),
    .tx_state      (tx_state),
    .train_timeout (train_timeout)
  );

  typedef struct {
    int         cyc;
    string      nm;
    logic [7:0] d;
    logic [1:0] s;
    logic       t;
    logic       r;
    bit         cd;
    bit         cs;
    bit         ct;
    bit         cr;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         stim_done = 1'b0;
  logic [6:0] mdl;

  always @(posedge fab_clk) cyc <= cyc + 1;

  task automatic push(input int off, input string nm, input logic [7:0] d, input logic [1:0] s,
                      input logic t, input logic r, input bit cd, input bit cs, input bit ct, input bit cr);
    exp_t e;
    e.cyc = cyc + off; e.nm = nm; e.d = d; e.s = s; e.t = t; e.r = r;
    e.cd = cd; e.cs = cs; e.ct = ct; e.cr = cr;
    sbq.push_back(e);
  endtask

  task automatic exp_nx(input string nm, input logic [7:0] d, input logic [1:0] s);
    push(1, nm, d, s, 1'b0, 1'b0, 1, 1, 0, 0);
  endtask

  task automatic exp_nxt(input string nm, input logic [7:0] d, input logic [1:0] s, input logic t);
    push(1, nm, d, s, t, 1'b0, 1, 1, 1, 0);
  endtask

  task automatic exp_now(input string nm, input logic [7:0] d, input logic [1:0] s, input logic t);
    push(0, nm, d, s, t, 1'b0, 1, 1, 1, 0);
  endtask

  task automatic exp_rdy(input string nm, input logic r);
    push(0, nm, 8'h00, 2'd0, 1'b0, r, 0, 0, 0, 1);
  endtask

  // Bit-serial reference: x^7+x^6+1, first generated bit into word bit 0.
  task automatic prbs_model(output logic [7:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      b    = mdl[6] ^ mdl[5];
      w[i] = b;
      mdl  = {mdl[5:0], b};
    end
  endtask

  task automatic prbs_step(input string nm);
    logic [7:0] w;
    prbs_model(w);
    exp_nx(nm, w, S_TRAIN);
  endtask

  task automatic tick();
    @(posedge fab_clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic done, input logic [1:0] sel,
                       input logic vld, input logic [7:0] din);
    train_req     = req;
    train_done    = done;
    pattern_sel   = sel;
    tx_data_valid = vld;
    tx_data_in    = din;
  endtask

  task automatic check_entry(input exp_t e);
    if (e.cd) begin
      checks++;
      if (tx_data_0 !== e.d) begin
        errors++;
        $display("FAIL %s tx_data_0: got %02h want %02h (cycle %0d)", e.nm, tx_data_0, e.d, e.cyc);
      end
    end
    if (e.cs) begin
      checks++;
      if (tx_state !== e.s) begin
        errors++;
        $display("FAIL %s tx_state: got %0d want %0d (cycle %0d)", e.nm, tx_state, e.s, e.cyc);
      end
    end
    if (e.ct) begin
      checks++;
      if (train_timeout !== e.t) begin
        errors++;
        $display("FAIL %s train_timeout: got %0b want %0b (cycle %0d)", e.nm, train_timeout, e.t, e.cyc);
      end
    end
    if (e.cr) begin
      checks++;
      if (tx_data_ready !== e.r) begin
        errors++;
        $display("FAIL %s tx_data_ready: got %0b want %0b (cycle %0d)", e.nm, tx_data_ready, e.r, e.cyc);
      end
    end
  endtask

  initial begin : monitor
    exp_t keep[$];
    forever begin
      @(negedge fab_clk);
      keep = {};
      foreach (sbq[k]) begin
        if (sbq[k].cyc == cyc) check_entry(sbq[k]);
        else keep.push_back(sbq[k]);
      end
      sbq = keep;
      if (stim_done) begin
        foreach (sbq[k]) begin
          checks++;
          errors++;
          $display("FAIL %s unchecked: due cycle %0d, run ended at cycle %0d", sbq[k].nm, sbq[k].cyc, cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: run exceeded time budget at cycle %0d, want completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    drive(0, 0, 2'd0, 0, 8'h00);
    tick(); tick();
    exp_now("reset_outputs", 8'h00, S_IDLE, 1'b0);
    exp_rdy("reset_ready", 1'b0);
    arst_n = 1'b1;
    tick();
    drive(0, 1, 2'd0, 0, 8'h00);
    exp_nxt("idle_ignores_done", 8'h00, S_IDLE, 1'b0);

    // Clock pattern, DONE pulse, sync words, then idle data
    tick(); drive(1, 0, 2'd0, 0, 8'h00);
    exp_nx("train_entry", 8'h00, S_TRAIN);
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_rdy("train_ready", 1'b0);
      exp_nx("clk_pattern", 8'h55, S_TRAIN);
    end
    tick(); drive(1, 1, 2'd0, 0, 8'h00);
    exp_nx("done_beats_req", 8'h55, S_SYNC);
    for (int k = 0; k < 4; k++) begin
      tick(); drive(0, 0, 2'd0, 0, 8'h00);
      exp_rdy("sync_ready", 1'b0);
      exp_nx("sync_word", 8'hB8, (k == 3) ? S_DATA : S_SYNC);
    end
    tick();
    exp_rdy("data_ready", 1'b1);
    exp_nxt("data_idle_word", 8'h00, S_DATA, 1'b1);

    // Handshake 01..10, then VALID low (DONE is ignored in DATA)
    for (int k = 1; k <= 16; k++) begin
      tick(); drive(0, 0, 2'd0, 1, 8'(k));
      exp_rdy("hs_ready", 1'b1);
      exp_nx("hs_word", 8'(k), S_DATA);
    end
    tick(); drive(0, 1, 2'd0, 0, 8'hFF);
    exp_nx("valid_low", 8'h00, S_DATA);

    // Retrain while a word is offered: it must be held and sent after resync
    tick(); drive(1, 0, 2'd0, 1, 8'hA5);
    exp_rdy("retrain_ready", 1'b0);
    exp_nxt("retrain_entry", 8'h00, S_TRAIN, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_nx("retrain_pattern", 8'h55, S_TRAIN);
    end
    tick(); drive(0, 1, 2'd0, 1, 8'hA5);
    exp_nx("retrain_done", 8'h55, S_SYNC);
    for (int k = 0; k < 4; k++) begin
      tick(); drive(0, 0, 2'd0, 1, 8'hA5);
      exp_rdy("resync_ready", 1'b0);
      exp_nx("resync_word", 8'hB8, (k == 3) ? S_DATA : S_SYNC);
    end
    tick();
    exp_rdy("held_ready", 1'b1);
    exp_nx("held_word_first", 8'hA5, S_DATA);
    tick(); drive(0, 0, 2'd0, 0, 8'h00);
    exp_nx("after_held", 8'h00, S_DATA);

    // PRBS7 over 127 words with user / alternate-clock selections interleaved
    tick(); drive(1, 0, 2'd1, 0, 8'h00);
    exp_nx("prbs_entry", 8'h00, S_TRAIN);
    mdl = 7'h7F;
    for (int k = 0; k < 60; k++) begin
      tick(); prbs_step("prbs_word");
    end
    for (int k = 0; k < 2; k++) begin
      tick(); drive(1, 0, 2'd2, 0, 8'h00);
      exp_nx("user_pattern", 8'h3C, S_TRAIN);
    end
    for (int k = 0; k < 2; k++) begin
      tick(); drive(1, 0, 2'd3, 0, 8'h00);
      exp_nx("sel3_clk_pattern", 8'h55, S_TRAIN);
    end
    tick(); drive(1, 0, 2'd1, 0, 8'h00);
    prbs_step("prbs_resume");
    for (int k = 0; k < 66; k++) begin
      tick(); prbs_step("prbs_word");
    end
    tick();
    begin
      logic [7:0] w;
      prbs_model(w);
      exp_nxt("prbs_after_timeout", w, S_TRAIN, 1'b1);
    end

    // Synchronous reset mid-PRBS with the timeout flag set
    tick(); tx_sync_rst = 1'b1;
    exp_nxt("sync_reset", 8'h00, S_IDLE, 1'b0);
    tick(); tx_sync_rst = 1'b0;
    exp_nx("srst_reentry", 8'h00, S_TRAIN);
    mdl = 7'h7F;
    for (int k = 0; k < 10; k++) begin
      tick(); prbs_step("prbs_after_srst");
    end

    // Asynchronous reset mid-PRBS
    tick();
    tick(); arst_n = 1'b0;
    exp_now("arst_mid_prbs", 8'h00, S_IDLE, 1'b0);
    tick();
    exp_now("arst_hold", 8'h00, S_IDLE, 1'b0);
    arst_n = 1'b1;
    exp_nx("arst_reentry", 8'h00, S_TRAIN);
    mdl = 7'h7F;
    for (int k = 0; k < 5; k++) begin
      tick(); prbs_step("prbs_after_arst");
    end
    tick(); tx_sync_rst = 1'b1;
    exp_nxt("sync_reset_2", 8'h00, S_IDLE, 1'b0);
    tick(); tx_sync_rst = 1'b0; drive(0, 0, 2'd0, 0, 8'h00);
    exp_nx("idle_after_srst", 8'h00, S_IDLE);

    // Timeout at 8 TRAIN cycles, flag through SYNC, cleared by SYNC->TRAIN
    tick(); drive(1, 0, 2'd0, 0, 8'h00);
    exp_nxt("to_entry", 8'h00, S_TRAIN, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_nxt("timeout_count", 8'h55, S_TRAIN, (k >= 8));
    end
    tick(); drive(1, 1, 2'd0, 0, 8'h00);
    exp_nxt("to_done", 8'h55, S_SYNC, 1'b1);
    tick(); drive(0, 0, 2'd0, 0, 8'h00);
    exp_nxt("to_sync_flag", 8'hB8, S_SYNC, 1'b1);
    tick(); drive(1, 0, 2'd0, 0, 8'h00);
    exp_nxt("sync_abort_clear", 8'hB8, S_TRAIN, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_nxt("timeout_count_2", 8'h55, S_TRAIN, (k >= 8));
    end
    tick(); drive(0, 1, 2'd0, 0, 8'h00);
    exp_nxt("to_done_2", 8'h55, S_SYNC, 1'b1);
    tick(); drive(0, 0, 2'd0, 0, 8'h00);
    exp_nxt("to_sync_flag_2", 8'hB8, S_SYNC, 1'b1);

    // Asynchronous reset mid-SYNC, then a full-length resync
    tick();
    tick(); arst_n = 1'b0;
    exp_now("arst_mid_sync", 8'h00, S_IDLE, 1'b0);
    exp_rdy("arst_ready", 1'b0);
    tick(); arst_n = 1'b1; drive(1, 0, 2'd0, 0, 8'h00);
    exp_nx("final_entry", 8'h00, S_TRAIN);
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_nx("final_pattern", 8'h55, S_TRAIN);
    end
    tick(); drive(0, 1, 2'd0, 0, 8'h00);
    exp_nx("final_done", 8'h55, S_SYNC);
    for (int k = 0; k < 4; k++) begin
      tick(); drive(0, 0, 2'd0, 0, 8'h00);
      exp_nx("final_sync", 8'hB8, (k == 3) ? S_DATA : S_SYNC);
    end
    tick(); drive(0, 0, 2'd0, 1, 8'h7E);
    exp_rdy("final_ready", 1'b1);
    exp_nx("final_word", 8'h7E, S_DATA);
    tick(); drive(0, 0, 2'd0, 0, 8'h00);
    exp_nx("final_idle", 8'h00, S_DATA);
    tick();
    tick();
    stim_done = 1'b1;
  end

endmodule

`default_nettype wire
